// File: rtl/dmem_resp_pkg.sv
// rtl/dmem_resp_pkg.sv - shared widths, FSM encoding and address range helper
package dmem_resp_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int BE_W   = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One extra bit so DEPTH=512 compares correctly against a 9-bit address.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input int depth);
    return {1'b0, a} < (ADDR_W + 1)'(depth);
  endfunction

endpackage

// File: rtl/dmem_resp_ram.sv
// rtl/dmem_resp_ram.sv - word memory, combinational read, per-byte synchronous write
module dmem_resp_ram
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   wr_be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range;
  logic [IDX_W-1:0]  idx;

  assign in_range = addr_ok(addr, DEPTH);
  assign idx      = addr[IDX_W-1:0];
  assign rdata    = in_range ? mem[idx] : '0;

  always_ff @(posedge clk) begin
    if (wr_en && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - single-outstanding data memory responder with fixed wait states
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam logic [CNT_W-1:0] WAIT_L = CNT_W'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              in_range;
  logic              ram_wr;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = WAIT_L;
          state_d = (WAIT_L == '0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Leaving on a count of 1 (or less) keeps the counter from wrapping.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  assign in_range = addr_ok(addr_q, DEPTH);
  assign busy     = (state_q != ST_IDLE);
  assign ack      = (state_q == ST_RESP);
  assign err      = ack && !in_range;
  assign rdata    = (ack && !we_q && in_range) ? ram_rdata : '0;
  // The write lands on the edge that leaves RESP; reset drops it with the state.
  assign ram_wr   = ack && we_q && in_range;

  dmem_resp_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .wr_en (ram_wr),
    .wr_be (be_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - randomized scoreboard bench for two dmem_resp configurations
module tb_dmem_resp;

  localparam int N   = 2;
  localparam int WC0 = 2;
  localparam int D0  = 256;
  localparam int WC1 = 0;
  localparam int D1  = 512;

  logic        clk = 1'b0;
  logic        rst   [N];
  logic        req   [N];
  logic        we    [N];
  logic [8:0]  addr  [N];
  logic [31:0] wdata [N];
  logic [3:0]  be    [N];
  logic        busy  [N];
  logic        ack   [N];
  logic [31:0] rdata [N];
  logic        err   [N];

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH(D0), .WAIT_CYCLES(WC0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .busy(busy[0]), .ack(ack[0]),
    .rdata(rdata[0]), .err(err[0])
  );

  dmem_resp #(.DEPTH(D1), .WAIT_CYCLES(WC1)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .busy(busy[1]), .ack(ack[1]),
    .rdata(rdata[1]), .err(err[1])
  );

  typedef struct {
    int          accept;
    int          ack_cyc;
    logic        err;
    logic        is_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq0 [$];
  exp_t        sbq1 [$];
  logic [31:0] mdl [N][512];
  int          last_ack [N];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: actual %h required %h", name, i, cyc, act, exp);
    end
  endtask

  task automatic mon(input int i);
    exp_t e;
    bit   have;
    bit   exp_ack;
    have = (i == 0) ? (sbq0.size() != 0) : (sbq1.size() != 0);
    if (have) e = (i == 0) ? sbq0[0] : sbq1[0];
    exp_ack = have && (cyc == e.ack_cyc);
    chk("busy", i, 32'(busy[i]), 32'(have && cyc >= e.accept));
    chk("ack", i, 32'(ack[i]), 32'(exp_ack));
    if (ack[i] && have) begin
      if (i == 0) void'(sbq0.pop_front()); else void'(sbq1.pop_front());
      chk("ack_cycle", i, 32'(cyc), 32'(e.ack_cyc));
      chk("err", i, 32'(err[i]), 32'(e.err));
      if (e.is_rd) chk("rdata", i, rdata[i], e.rdata);
    end else if (!ack[i]) begin
      chk("idle_rdata", i, rdata[i], 32'h0);
      chk("idle_err", i, 32'(err[i]), 32'h0);
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  function automatic exp_t predict(input int i, input logic w, input logic [8:0] a);
    exp_t e;
    int   wc  = (i == 0) ? WC0 : WC1;
    int   dep = (i == 0) ? D0 : D1;
    e.accept  = (cyc + 1 > last_ack[i] + 2) ? cyc + 1 : last_ack[i] + 2;
    e.ack_cyc = e.accept + wc;
    e.is_rd   = !w;
    e.err     = (int'(a) >= dep);
    e.rdata   = (!w && int'(a) < dep) ? mdl[i][a] : 32'h0;
    return e;
  endfunction

  task automatic issue(input int i, input logic w, input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit scramble);
    exp_t e;
    bit   done = 0;
    int   dep  = (i == 0) ? D0 : D1;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
    e = predict(i, w, a);
    if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk); #1;
      if (ack[i]) done = 1;
      else if (scramble && cyc >= e.accept) begin
        req[i]   = 1'($urandom_range(0, 1));
        we[i]    = 1'($urandom_range(0, 1));
        addr[i]  = 9'($urandom);
        wdata[i] = $urandom;
        be[i]    = 4'($urandom);
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout inst%0d cycle %0d: actual no ack required ack", i, cyc);
    end else begin
      last_ack[i] = cyc;
      if (w && int'(a) < dep)
        for (int bb = 0; bb < 4; bb++)
          if (b[bb]) mdl[i][a][8*bb +: 8] = d[8*bb +: 8];
    end
  endtask

  task automatic idle(input int i, input int n);
    req[i] = 1'b0;
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic abort_write(input int i, input logic [8:0] a, input logic [31:0] d);
    exp_t e;
    req[i] = 1'b1; we[i] = 1'b1; addr[i] = a; wdata[i] = d; be[i] = 4'hF;
    e = predict(i, 1'b1, a);
    if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
    for (int k = 0; k < 16 && cyc != e.accept; k++) begin
      @(negedge clk); #1;
    end
    rst[i] = 1'b1;
    req[i] = 1'b0;
    if (i == 0) sbq0.delete(); else sbq1.delete();
    repeat (2) begin
      @(negedge clk); #1;
    end
    rst[i] = 1'b0;
    last_ack[i] = -100;
  endtask

  task automatic run(input int i);
    for (int a = 0; a < 16; a++) begin
      issue(i, 1'b1, 9'(a), $urandom, 4'hF, 0);
      idle(i, $urandom_range(0, 1));
    end
    if (i == 0) begin
      issue(0, 1'b1, 9'd5, 32'hDEADBEEF, 4'hF, 0);
      idle(0, 1);
      issue(0, 1'b0, 9'd5, 32'h0, 4'h0, 0);
      issue(0, 1'b1, 9'd5, 32'h0000AA00, 4'b0010, 0);
      issue(0, 1'b0, 9'd5, 32'h0, 4'h0, 0);
      issue(0, 1'b1, 9'd5, 32'h55555555, 4'h0, 0);
      issue(0, 1'b0, 9'd5, 32'h0, 4'h0, 0);
      issue(0, 1'b1, 9'd300, 32'hCAFEF00D, 4'hF, 0);
      issue(0, 1'b0, 9'd300, 32'h0, 4'h0, 0);
      issue(0, 1'b1, 9'd7, 32'h11111111, 4'hF, 0);
      idle(0, 2);
      abort_write(0, 9'd7, 32'h22222222);
      issue(0, 1'b0, 9'd7, 32'h0, 4'h0, 0);
      issue(0, 1'b1, 9'd9, 32'h12345678, 4'hF, 1);
      issue(0, 1'b0, 9'd9, 32'h0, 4'h0, 1);
    end else begin
      for (int k = 0; k < 3; k++) issue(1, 1'b0, 9'(k + 2), 32'h0, 4'h0, 0);
    end
    idle(i, 1);
    for (int n = 0; n < 120; n++) begin
      logic       w  = 1'($urandom_range(0, 1));
      logic [8:0] a  = (i == 0 && $urandom_range(0, 5) == 0) ? 9'($urandom_range(256, 511))
                                                             : 9'($urandom_range(0, 15));
      issue(i, w, a, $urandom, 4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle(i, $urandom_range(0, 3));
    end
    idle(i, 2);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0;
      wdata[i] = '0; be[i] = '0; last_ack[i] = -100;
    end
    repeat (3) @(negedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    fork
      run(0);
      run(1);
    join
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
